adpll_loop_ctrl: RTL and testbench

ADPLL_LOOP_CTRL -- requirements
Module: adpll_loop_ctrl

---
 rtl/adpll_loop_ctrl.sv | 162 ++++++++++++++++
 tb/tb_adpll_loop_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: TDC window sequencing, PI loop filter and DCO word update.
// Optional lock detector enabled by defining ADPLL_LOCK_DET_EN.
module adpll_loop_ctrl #(
  parameter int WIN_CYC  = 40,
  parameter int DCO_W    = 10,
  parameter int KP_SHIFT = 2,
  parameter int KI_SHIFT = 5,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [31:0]       up_error,
  input  logic [31:0]       dwn_error,
  output logic              tdc_rst,
  output logic [DCO_W-1:0]  dco_code,
  output logic              dco_valid,
  output logic signed [6:0] phase_err,
  output logic              locked,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ARM, WAIT, SAMPLE, FILTER, UPDATE} state_t;

  localparam logic signed [17:0] DCO_MID = 18'sd1 <<< (DCO_W - 1);
  localparam logic signed [17:0] DCO_MAX = (18'sd1 <<< DCO_W) - 18'sd1;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [7:0]              r_waitCnt;
  logic [5:0]              r_upCnt;
  logic [5:0]              r_dwnCnt;
  logic signed [6:0]       r_phaseErr;
  logic signed [15:0]      r_integ;
  logic [DCO_W-1:0]        r_dcoCode;
  logic signed [6:0]       w_diff;
  logic signed [16:0]      w_integSum;
  logic signed [15:0]      w_integNext;
  logic signed [17:0]      w_integTerm;
  logic signed [17:0]      w_phaseTerm;
  logic signed [17:0]      w_dcoSum;
  logic [DCO_W-1:0]        w_dcoNext;

  // Bubbles in the thermometer code are tolerated by counting every set bit.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    tdc_rst     = 1'b0;
    dco_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (en) w_nextState = ARM;
      end
      ARM: begin
        tdc_rst     = 1'b1;
        w_nextState = WAIT;
      end
      WAIT:   if (r_waitCnt == 8'(WIN_CYC - 1)) w_nextState = SAMPLE;
      SAMPLE: w_nextState = FILTER;
      FILTER: w_nextState = UPDATE;
      UPDATE: begin
        dco_valid   = 1'b1;
        w_nextState = en ? ARM : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_diff     = $signed({1'b0, r_upCnt}) - $signed({1'b0, r_dwnCnt});
  assign w_integSum = {r_integ[15], r_integ} + {{10{w_diff[6]}}, w_diff};

  always_comb begin
    w_integNext = w_integSum[15:0];
    if (w_integSum > 17'sd32767)       w_integNext = 16'sh7FFF;
    else if (w_integSum < -17'sd32768) w_integNext = 16'sh8000;
  end

  // The new DCO word uses the integrator value being written in the same cycle.
  assign w_integTerm = $signed({{2{w_integNext[15]}}, w_integNext}) >>> KI_SHIFT;
  assign w_phaseTerm = $signed({{11{w_diff[6]}}, w_diff}) <<< KP_SHIFT;
  assign w_dcoSum    = DCO_MID + w_integTerm + w_phaseTerm;

  always_comb begin
    w_dcoNext = w_dcoSum[DCO_W-1:0];
    if (w_dcoSum < 18'sd0)       w_dcoNext = '0;
    else if (w_dcoSum > DCO_MAX) w_dcoNext = DCO_MAX[DCO_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waitCnt  <= '0;
      r_upCnt    <= '0;
      r_dwnCnt   <= '0;
      r_phaseErr <= '0;
      r_integ    <= '0;
      r_dcoCode  <= DCO_MID[DCO_W-1:0];
    end else begin
      case (r_state)
        ARM:  r_waitCnt <= '0;
        WAIT: r_waitCnt <= r_waitCnt + 8'd1;
        SAMPLE: begin
          r_upCnt  <= popcount(up_error);
          r_dwnCnt <= popcount(dwn_error);
        end
        FILTER: begin
          r_phaseErr <= w_diff;
          r_integ    <= w_integNext;
          r_dcoCode  <= w_dcoNext;
        end
        default: ;
      endcase
    end
  end

  assign phase_err = r_phaseErr;
  assign dco_code  = r_dcoCode;

`ifdef ADPLL_LOCK_DET_EN
  localparam int LOCK_W = $clog2(LOCK_CNT + 1);

  logic [LOCK_W-1:0] r_lockCnt;
  logic              r_locked;
  logic [6:0]        w_absErr;

  assign w_absErr = w_diff[6] ? 7'(-w_diff) : w_diff;

  // Lock state changes on the same edge that publishes the new DCO word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lockCnt <= '0;
      r_locked  <= 1'b0;
    end else if (r_state == FILTER) begin
      if (w_absErr <= 7'(LOCK_TOL)) begin
        if (r_lockCnt != LOCK_W'(LOCK_CNT)) r_lockCnt <= r_lockCnt + LOCK_W'(1);
        if (r_lockCnt >= LOCK_W'(LOCK_CNT - 1)) r_locked <= 1'b1;
      end else begin
        r_lockCnt <= '0;
        r_locked  <= 1'b0;
      end
    end
  end

  assign locked = r_locked;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Directed self-checking bench for adpll_loop_ctrl (default parameters).
// Lock expectations follow ADPLL_LOCK_DET_EN as defined for the build.
module tb_adpll_loop_ctrl;

  localparam int WIN = 40;
`ifdef ADPLL_LOCK_DET_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [31:0]       upError;
  logic [31:0]       dwnError;
  logic              tdcRst;
  logic [9:0]        dcoCode;
  logic              dcoValid;
  logic signed [6:0] phaseErr;
  logic              locked;
  logic              busy;

  int checkCount = 0;
  int errorCount = 0;

  adpll_loop_ctrl #(.WIN_CYC(WIN)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .up_error  (upError),
    .dwn_error (dwnError),
    .tdc_rst   (tdcRst),
    .dco_code  (dcoCode),
    .dco_valid (dcoValid),
    .phase_err (phaseErr),
    .locked    (locked),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [31:0] u, input logic [31:0] d);
    @(negedge clk);
    en       = e;
    upError  = u;
    dwnError = d;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_tdc_rst", tdcRst, 0);
    checkOutput("rst_valid", dcoValid, 0);
    checkOutput("rst_dco", dcoCode, 512);
    checkOutput("rst_phase", phaseErr, 0);
    checkOutput("rst_locked", locked, 0);
    reset = 1'b0;
  endtask

  task automatic waitValid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < WIN + 10; i++) begin
      @(negedge clk);
      if (dcoValid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("valid_timeout", 0, 1);
  endtask

  typedef struct {
    logic [31:0] up;
    logic [31:0] dwn;
    int          phase;
    int          dco;
  } vec_t;

  vec_t vecs[3];
  int   pulses;
  int   valids;
  int   busyCount;
  int   integM;
  int   dcoE;

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    upError  = '0;
    dwnError = '0;

    // Basic measurement: 8 - 4 ones gives +4, DCO = 512 + 0 + 16.
    applyReset();
    applyStimulus(1'b1, 32'h0000_00FF, 32'h0000_000F);
    @(negedge clk);
    checkOutput("arm_tdc_rst", tdcRst, 1);
    checkOutput("arm_busy", busy, 1);
    pulses = 0;
    valids = 0;
    repeat (WIN + 2) begin
      @(negedge clk);
      pulses += int'(tdcRst);
      valids += int'(dcoValid);
    end
    checkOutput("tdc_rst_once", pulses, 0);
    checkOutput("no_early_valid", valids, 0);
    @(negedge clk);
    checkOutput("first_valid", dcoValid, 1);
    checkOutput("first_phase", phaseErr, 4);
    checkOutput("first_dco", dcoCode, 528);
    en = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_update", busy, 0);
    checkOutput("valid_one_cycle", dcoValid, 0);

    // Reset mid-WAIT, then no activity while en stays low.
    applyStimulus(1'b1, 32'h0000_00FF, 32'h0000_000F);
    waitValid();
    checkOutput("second_dco", dcoCode, 528);
    repeat (10) @(negedge clk);
    checkOutput("wait_busy", busy, 1);
    #2 reset = 1'b1;
    en = 1'b0;
    #1;
    checkOutput("async_busy", busy, 0);
    checkOutput("async_dco", dcoCode, 512);
    checkOutput("async_locked", locked, 0);
    checkOutput("async_tdc_rst", tdcRst, 0);
    @(negedge clk);
    checkOutput("async_phase", phaseErr, 0);
    reset = 1'b0;
    pulses = 0;
    busyCount = 0;
    repeat (20) begin
      @(negedge clk);
      pulses += int'(tdcRst);
      busyCount += int'(busy);
    end
    checkOutput("idle_no_tdc_rst", pulses, 0);
    checkOutput("idle_no_busy", busyCount, 0);

    // en dropped in WAIT: the measurement completes, then the loop stops.
    applyStimulus(1'b1, 32'h0000_00FF, 32'h0000_000F);
    repeat (6) @(negedge clk);
    en = 1'b0;
    waitValid();
    checkOutput("drop_phase", phaseErr, 4);
    checkOutput("drop_dco", dcoCode, 528);
    pulses = 0;
    busyCount = 0;
    repeat (50) begin
      @(negedge clk);
      pulses += int'(tdcRst);
      busyCount += int'(busy);
    end
    checkOutput("drop_no_tdc_rst", pulses, 0);
    checkOutput("drop_no_busy", busyCount, 0);

    // Directed vectors including bubbled codes and negative error.
    vecs[0] = '{32'h0000_F0F3, 32'h0000_0101,   8, 544};
    vecs[1] = '{32'h0000_0000, 32'hFFFF_FFFF, -32, 383};
    vecs[2] = '{32'h0000_0001, 32'h8000_0001,  -1, 507};
    applyReset();
    for (int v = 0; v < 3; v++) begin
      applyStimulus(1'b1, vecs[v].up, vecs[v].dwn);
      waitValid();
      checkOutput($sformatf("vec%0d_phase", v), phaseErr, vecs[v].phase);
      checkOutput($sformatf("vec%0d_dco", v), dcoCode, vecs[v].dco);
    end
    en = 1'b0;

    // Lock detection: 16 zero-error updates, then one +3 update.
    applyReset();
    applyStimulus(1'b1, 32'h0000_FFFF, 32'h0000_FFFF);
    for (int k = 1; k <= 16; k++) begin
      waitValid();
      checkOutput($sformatf("lock_upd%0d", k), locked, (LOCK_EN && k == 16) ? 1 : 0);
      checkOutput($sformatf("lock_dco%0d", k), dcoCode, 512);
    end
    upError  = 32'h0000_0007;
    dwnError = 32'h0000_0000;
    waitValid();
    checkOutput("unlock_phase", phaseErr, 3);
    checkOutput("unlock_dco", dcoCode, 524);
    checkOutput("unlock_locked", locked, 0);
    en = 1'b0;

    // Sustained +32: DCO ramps, clamps at 1023 and never wraps back down.
    applyReset();
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
    integM = 0;
    for (int n = 1; n <= 1030; n++) begin
      waitValid();
      integM = (integM + 32 > 32767) ? 32767 : integM + 32;
      dcoE   = 512 + (integM >>> 5) + 128;
      if (dcoE > 1023) dcoE = 1023;
      checkOutput($sformatf("ramp_phase%0d", n), phaseErr, 32);
      checkOutput($sformatf("ramp_dco%0d", n), dcoCode, dcoE);
    end
    en = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
